// File: rtl/calc_pkg.sv
// Shared definitions for the sign-magnitude to BCD result decoder.
// Holds the FSM state encoding and default operand/digit sizes.
package calc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int MAG_W_DEF  = 17;
    localparam int DIGITS_DEF = 6;

endpackage

// File: rtl/bcd_adj3.sv
// Double-dabble digit correction: add 3 to a BCD digit of 5 or more
// so the following left shift carries correctly into the next digit.
module bcd_adj3 (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    assign dout = (din >= 4'd5) ? (din + 4'd3) : din;

endmodule

// File: rtl/result_bcd_decoder.sv
// Sequential shift-and-add-3 converter from a sign-magnitude result to BCD
// digits plus a display sign; one magnitude bit is consumed per clock.
//
// state | meaning
// IDLE  | waiting for start; captures Result when start is sampled high
// SHIFT | one adjust-and-shift step per edge, MAG_W edges in total
// DONE  | single-cycle completion strobe, then back to IDLE
import calc_pkg::*;

module result_bcd_decoder #(
    parameter int MAG_W  = MAG_W_DEF,
    parameter int DIGITS = DIGITS_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [MAG_W:0]        Result,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  neg,
    output logic                  busy,
    output logic                  done
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(MAG_W + 1);

    state_t             state;
    state_t             state_next;
    logic [MAG_W-1:0]   mag;
    logic               sign;
    logic               mag_nz;
    logic [BCD_W-1:0]   scratch;
    logic [BCD_W-1:0]   scratch_adj;
    logic [BCD_W-1:0]   scratch_next;
    logic [CNT_W-1:0]   cnt;
    logic               last_bit;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_adj3 u_adj (
            .din  (scratch[4*g +: 4]),
            .dout (scratch_adj[4*g +: 4])
        );
    end

    // The top digit never overflows for legal DIGITS, so the bit shifted out is always 0.
    assign scratch_next = (scratch_adj << 1) | BCD_W'(mag[MAG_W-1]);
    assign last_bit     = (cnt == CNT_W'(MAG_W - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (last_bit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mag     <= '0;
            sign    <= 1'b0;
            mag_nz  <= 1'b0;
            scratch <= '0;
            cnt     <= '0;
            bcd     <= '0;
            neg     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sign    <= Result[MAG_W];
                        mag     <= Result[MAG_W-1:0];
                        mag_nz  <= |Result[MAG_W-1:0];
                        scratch <= '0;
                        cnt     <= '0;
                    end
                end
                SHIFT: begin
                    scratch <= scratch_next;
                    mag     <= mag << 1;
                    cnt     <= cnt + CNT_W'(1);
                    if (last_bit) begin
                        bcd <= scratch_next;
                        // Negative zero is shown as +0.
                        neg <= sign & mag_nz;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_result_bcd_decoder.sv
// Directed bench for result_bcd_decoder: a vector table of conversions plus
// hand-written sequences for ignored start, back-to-back starts and mid-shift reset.
module tb_result_bcd_decoder;

    localparam int MAG_W  = 17;
    localparam int DIGITS = 6;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                start;
    logic [MAG_W:0]      Result;
    logic [4*DIGITS-1:0] bcd;
    logic                neg;
    logic                busy;
    logic                done;

    int checks   = 0;
    int failures = 0;

    result_bcd_decoder #(.MAG_W(MAG_W), .DIGITS(DIGITS)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .Result (Result),
        .bcd    (bcd),
        .neg    (neg),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        sign;
        logic [16:0] mag;
        logic [23:0] exp_bcd;
        logic        exp_neg;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic run_conv(input logic s, input logic [16:0] m,
                            output int busy_cnt, output bit seen_done);
        @(negedge clk);
        Result = {s, m};
        start  = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        busy_cnt  = 0;
        seen_done = 1'b0;
        for (int i = 0; i < 40 && !seen_done; i++) begin
            if (busy) busy_cnt++;
            if (done) seen_done = 1'b1;
            else @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  bc;
        bit  sd;
        int  done_cnt;
        int  first_done;
        int  second_done;

        vecs[0] = '{1'b0, 17'd0,      24'h000000, 1'b0};
        vecs[1] = '{1'b1, 17'd510,    24'h000510, 1'b1};
        vecs[2] = '{1'b1, 17'd0,      24'h000000, 1'b0};
        vecs[3] = '{1'b0, 17'd131071, 24'h131071, 1'b0};
        vecs[4] = '{1'b0, 17'd99999,  24'h099999, 1'b0};
        vecs[5] = '{1'b0, 17'd100000, 24'h100000, 1'b0};
        vecs[6] = '{1'b1, 17'd1,      24'h000001, 1'b1};
        vecs[7] = '{1'b0, 17'd12345,  24'h012345, 1'b0};
        vecs[8] = '{1'b0, 17'd9,      24'h000009, 1'b0};
        vecs[9] = '{1'b1, 17'd90909,  24'h090909, 1'b1};

        rst_n  = 1'b0;
        start  = 1'b0;
        Result = '0;
        #1;
        check("reset_bcd",  32'(bcd),  32'h0);
        check("reset_neg",  32'(neg),  32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_done", 32'(done), 32'h0);
        #20 rst_n = 1'b1;

        for (int v = 0; v < 10; v++) begin
            run_conv(vecs[v].sign, vecs[v].mag, bc, sd);
            check($sformatf("vec%0d_done", v),  32'(sd),   32'h1);
            check($sformatf("vec%0d_busy", v),  32'(bc),   32'd17);
            check($sformatf("vec%0d_bcd", v),   32'(bcd),  32'(vecs[v].exp_bcd));
            check($sformatf("vec%0d_neg", v),   32'(neg),  32'(vecs[v].exp_neg));
            @(negedge clk);
            check($sformatf("vec%0d_done_width", v), 32'(done), 32'h0);
        end

        // Start re-pulse and Result change during SHIFT must be ignored.
        @(negedge clk);
        Result = {1'b0, 17'd4321};
        start  = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 45; i++) begin
            if (i == 5) begin
                Result = {1'b1, 17'd99};
                start  = 1'b1;
            end
            if (i == 6) start = 1'b0;
            if (done) done_cnt++;
            @(negedge clk);
        end
        check("ignore_done_cnt", 32'(done_cnt), 32'd1);
        check("ignore_bcd",      32'(bcd),      32'h004321);
        check("ignore_neg",      32'(neg),      32'h0);

        // Start held high: a new conversion every MAG_W+2 cycles.
        Result      = {1'b1, 17'd55};
        start       = 1'b1;
        first_done  = -1;
        second_done = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done) begin
                if (first_done < 0) first_done = i;
                else if (second_done < 0) second_done = i;
            end
        end
        start = 1'b0;
        check("held_period", 32'(second_done - first_done), 32'd19);
        for (int i = 0; i < 25 && (busy || done); i++) @(negedge clk);
        @(negedge clk);
        check("held_bcd", 32'(bcd), 32'h000055);
        check("held_neg", 32'(neg), 32'h1);

        // Reset at SHIFT cycle 8 aborts the conversion.
        Result = {1'b0, 17'd777};
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 7; i++) @(negedge clk);
        check("abort_busy_before", 32'(busy), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_bcd",  32'(bcd),  32'h0);
        check("abort_neg",  32'(neg),  32'h0);
        check("abort_busy", 32'(busy), 32'h0);
        check("abort_done", 32'(done), 32'h0);
        #5 rst_n = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done || busy) done_cnt++;
        end
        check("abort_no_done", 32'(done_cnt), 32'd0);

        run_conv(1'b0, 17'd2468, bc, sd);
        check("post_reset_done", 32'(sd),  32'h1);
        check("post_reset_busy", 32'(bc),  32'd17);
        check("post_reset_bcd",  32'(bcd), 32'h002468);
        check("post_reset_neg",  32'(neg), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
